multicycle_control: RTL and testbench



---
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_control.sv | 136 +++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle MIPS datapath.
// Optional `JUMP_EN enables the J instruction; otherwise opcode 000010 is illegal.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        WB_MEM    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        WB_R      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        EXEC_I    = 4'd10,
        WB_I      = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef JUMP_EN
    localparam logic [5:0] OP_J    = 6'b000010;
`endif

    state_t cur, nxt;
    logic   is_lw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= FETCH;
        else        cur <= nxt;
    end

    // opcode is only valid in DECODE, so remember LW vs SW for MEM_ADDR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             is_lw <= 1'b0;
        else if (cur == DECODE) is_lw <= (opcode == OP_LW);
    end

    assign state = cur;

    always_comb begin
        nxt         = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        // outputs are forced low for as long as reset is held
        if (rst_n) begin
            case (cur)
                FETCH: begin
                    nxt     = mem_ready ? DECODE : FETCH;
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: nxt = MEM_ADDR;
                        OP_R:         nxt = EXEC_R;
                        OP_BEQ:       nxt = BRANCH;
                        OP_ADDI:      nxt = EXEC_I;
`ifdef JUMP_EN
                        OP_J:         nxt = JUMP;
`endif
                        default: begin
                            nxt     = FETCH;
                            illegal = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    nxt     = is_lw ? MEM_READ : MEM_WRITE;
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEM_READ: begin
                    nxt     = mem_ready ? WB_MEM : MEM_READ;
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                WB_MEM: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    nxt        = mem_ready ? FETCH : MEM_WRITE;
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                EXEC_R: begin
                    nxt     = WB_R;
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                WB_R: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                end
`ifdef JUMP_EN
                JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
`endif
                EXEC_I: begin
                    nxt     = WB_I;
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                WB_I: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: nxt = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control.
// Directed instruction sequences; expected outputs queued per cycle, checked by a monitor.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA, instr_done, illegal;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic [3:0] state;
    logic [21:0] got;

    typedef struct { logic [21:0] v; int id; } exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0, sent = 0;
    event chk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .state(state), .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, state, instr_done, illegal};

    // strobe order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite RegWrite RegDst ALUSrcA
    function automatic logic [21:0] expect_v(input logic r, input logic mr,
                                             input logic [5:0] op, input logic [3:0] st);
        logic ill;
        if (!r) return 22'd0;
`ifdef JUMP_EN
        ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
`else
        ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000});
`endif
        case (st)
            4'd0:  return {mr, 5'b00100, mr, 3'b000, 2'b01, 2'b00, 2'b00, st, 1'b0, 1'b0};
            4'd1:  return {10'b0000000000, 2'b11, 2'b00, 2'b00, st, 1'b0, ill};
            4'd2:  return {10'b0000000001, 2'b10, 2'b00, 2'b00, st, 1'b0, 1'b0};
            4'd3:  return {10'b0011000000, 2'b00, 2'b00, 2'b00, st, 1'b0, 1'b0};
            4'd4:  return {10'b0000010100, 2'b00, 2'b00, 2'b00, st, 1'b1, 1'b0};
            4'd5:  return {10'b0010100000, 2'b00, 2'b00, 2'b00, st, mr,   1'b0};
            4'd6:  return {10'b0000000001, 2'b00, 2'b00, 2'b10, st, 1'b0, 1'b0};
            4'd7:  return {10'b0000000110, 2'b00, 2'b00, 2'b00, st, 1'b1, 1'b0};
            4'd8:  return {10'b0100000001, 2'b00, 2'b01, 2'b01, st, 1'b1, 1'b0};
            4'd9:  return {10'b1000000000, 2'b00, 2'b10, 2'b00, st, 1'b1, 1'b0};
            4'd10: return {10'b0000000001, 2'b10, 2'b00, 2'b00, st, 1'b0, 1'b0};
            4'd11: return {10'b0000000100, 2'b00, 2'b00, 2'b00, st, 1'b1, 1'b0};
            default: return 22'h3fffff;
        endcase
    endfunction

    task automatic push(input logic r, input logic mr, input logic [5:0] op, input logic [3:0] st);
        exp_t e;
        e.v = expect_v(r, mr, op, st);
        e.id = sent;
        q.push_back(e);
        sent++;
    endtask

    task automatic cyc(input logic r, input logic mr, input logic [5:0] op, input logic [3:0] st);
        @(posedge clk);
        #1;
        rst_n = r;
        mem_ready = mr;
        opcode = op;
        push(r, mr, op, st);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL step %0d: got %h (state %0d) want %h", e.id, got, state, e.v);
                end
            end
        end
    end

    initial begin
        // reset with mem_ready high: FETCH strobes must stay masked
        repeat (3) cyc(1'b0, 1'b1, 6'b000000, 4'd0);
        // R-type, FETCH stalled once first
        cyc(1, 0, 6'b000000, 0); cyc(1, 1, 6'b000000, 0); cyc(1, 1, 6'b000000, 1);
        cyc(1, 1, 6'b000000, 6); cyc(1, 1, 6'b000000, 7);
        // LW, opcode changes after DECODE are ignored; MEM_READ stalls twice
        cyc(1, 1, 6'b100011, 0); cyc(1, 1, 6'b100011, 1); cyc(1, 1, 6'b101011, 2);
        cyc(1, 0, 6'b101011, 3); cyc(1, 0, 6'b000100, 3); cyc(1, 1, 6'b000000, 3);
        cyc(1, 1, 6'b000000, 4);
        // BEQ
        cyc(1, 1, 6'b000100, 0); cyc(1, 1, 6'b000100, 1); cyc(1, 1, 6'b000100, 8);
        // ADDI
        cyc(1, 1, 6'b001000, 0); cyc(1, 1, 6'b001000, 1); cyc(1, 1, 6'b001000, 10);
        cyc(1, 1, 6'b001000, 11);
        // illegal
        cyc(1, 1, 6'b111111, 0); cyc(1, 1, 6'b111111, 1);
        // SW completing with one write stall
        cyc(1, 1, 6'b101011, 0); cyc(1, 1, 6'b101011, 1); cyc(1, 1, 6'b101011, 2);
        cyc(1, 0, 6'b101011, 5); cyc(1, 1, 6'b101011, 5);
        // J
        cyc(1, 1, 6'b000010, 0); cyc(1, 1, 6'b000010, 1);
`ifdef JUMP_EN
        cyc(1, 1, 6'b000010, 9);
`endif
        // SW aborted by reset while the write is stalled
        cyc(1, 1, 6'b101011, 0); cyc(1, 1, 6'b101011, 1); cyc(1, 1, 6'b101011, 2);
        cyc(1, 0, 6'b101011, 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push(1'b0, 1'b0, 6'b101011, 4'd0);
        ->chk;
        cyc(0, 1, 6'b101011, 0);
        cyc(1, 1, 6'b000000, 0); cyc(1, 1, 6'b000000, 1);
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
